// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Round-robin front end that shares one true dual-port RAM among N_REQ
// requesters. Up to two requests are granted per cycle. The first goes to
// port A and the second to port B. Granted commands are registered onto the
// RAM pins. Read data is steered back to the issuing requester through a
// small return pipeline that tracks the RAM latency.
module dpram_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int AW      = 6,
    parameter int DW      = 8,
    parameter int RAM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [N_REQ*DW-1:0] rdata,
    output logic                ram_we_a,
    output logic [AW-1:0]       ram_addr_a,
    output logic [DW-1:0]       ram_data_a,
    input  logic [DW-1:0]       ram_q_a,
    output logic                ram_we_b,
    output logic [AW-1:0]       ram_addr_b,
    output logic [DW-1:0]       ram_data_b,
    input  logic [DW-1:0]       ram_q_b
);

    localparam int          IDW   = $clog2(N_REQ);
    localparam int unsigned NQ    = N_REQ;
    localparam int unsigned DEPTH = 1 + RAM_LAT;

    // One return-pipeline entry: a read in flight on one RAM port.
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           port;   // 0 = port A, 1 = port B
    } ret_t;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] last_id;
    logic [IDW-1:0] scan_id;
    logic [N_REQ-1:0] req_eff;

    logic           slot_a_vld;
    logic           slot_b_vld;
    logic           slot_b_gnt;
    logic           collide;
    logic [IDW-1:0] id_a;
    logic [IDW-1:0] id_b;

    logic           we_a_sel;
    logic           we_b_sel;
    logic [AW-1:0]  addr_a_sel;
    logic [AW-1:0]  addr_b_sel;
    logic [DW-1:0]  wdata_a_sel;
    logic [DW-1:0]  wdata_b_sel;

    ret_t           pipe_a [DEPTH];
    ret_t           pipe_b [DEPTH];
    ret_t           tail_a;
    ret_t           tail_b;
    logic [N_REQ-1:0] ret_vec;

    // Requests are ignored while reset is asserted so gnt reads zero.
    assign req_eff = rst_n ? req : '0;

    // Scan from the round-robin pointer upward; first hit is slot A, second is slot B.
    always_comb begin
        slot_a_vld = 1'b0;
        slot_b_vld = 1'b0;
        id_a       = '0;
        id_b       = '0;
        scan_id    = '0;
        for (int unsigned k = 0; k < NQ; k++) begin
            scan_id = IDW'((32'(rr_ptr) + k) % NQ);
            if (req_eff[scan_id]) begin
                if (!slot_a_vld) begin
                    slot_a_vld = 1'b1;
                    id_a       = scan_id;
                end else if (!slot_b_vld) begin
                    slot_b_vld = 1'b1;
                    id_b       = scan_id;
                end
            end
        end
    end

    // Select slot fields, apply the same-address collision rule, form gnt and the next pointer.
    always_comb begin
        we_a_sel    = req_we[id_a];
        we_b_sel    = req_we[id_b];
        addr_a_sel  = req_addr[int'(id_a)*AW +: AW];
        addr_b_sel  = req_addr[int'(id_b)*AW +: AW];
        wdata_a_sel = req_wdata[int'(id_a)*DW +: DW];
        wdata_b_sel = req_wdata[int'(id_b)*DW +: DW];

        // A read and a write, or two writes, to one address are serialised:
        // slot B waits so its access is ordered after slot A's.
        collide    = slot_a_vld && slot_b_vld && (addr_a_sel == addr_b_sel) &&
                     (we_a_sel || we_b_sel);
        slot_b_gnt = slot_b_vld && !collide;

        gnt = '0;
        if (slot_a_vld) gnt[id_a] = 1'b1;
        if (slot_b_gnt) gnt[id_b] = 1'b1;

        last_id = slot_b_gnt ? id_b : id_a;
        rr_next = (last_id == IDW'(N_REQ - 1)) ? '0 : last_id + IDW'(1);
    end

    // Advance the round-robin pointer and register granted commands onto the RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_data_a <= '0;
            ram_we_b   <= 1'b0;
            ram_addr_b <= '0;
            ram_data_b <= '0;
        end else begin
            if (slot_a_vld) rr_ptr <= rr_next;

            ram_we_a <= slot_a_vld && we_a_sel;
            if (slot_a_vld) begin
                ram_addr_a <= addr_a_sel;
                ram_data_a <= wdata_a_sel;
            end

            ram_we_b <= slot_b_gnt && we_b_sel;
            if (slot_b_gnt) begin
                ram_addr_b <= addr_b_sel;
                ram_data_b <= wdata_b_sel;
            end
        end
    end

    // Track granted reads until their RAM data is valid; stage 0 lines up with the command cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                pipe_a[s] <= '0;
                pipe_b[s] <= '0;
            end
        end else begin
            pipe_a[0] <= '{valid: slot_a_vld && !we_a_sel, id: id_a, port: 1'b0};
            pipe_b[0] <= '{valid: slot_b_gnt && !we_b_sel, id: id_b, port: 1'b1};
            for (int unsigned s = 1; s < DEPTH; s++) begin
                pipe_a[s] <= pipe_a[s-1];
                pipe_b[s] <= pipe_b[s-1];
            end
        end
    end

    assign tail_a = pipe_a[DEPTH-1];
    assign tail_b = pipe_b[DEPTH-1];

    // Decode which requesters receive read data this cycle.
    always_comb begin
        ret_vec = '0;
        if (tail_a.valid) ret_vec[tail_a.id] = 1'b1;
        if (tail_b.valid) ret_vec[tail_b.id] = 1'b1;
    end

    // Register the returning data into the owner's rdata slice and pulse its rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= ret_vec;
            if (tail_a.valid)
                rdata[int'(tail_a.id)*DW +: DW] <= tail_a.port ? ram_q_b : ram_q_a;
            if (tail_b.valid)
                rdata[int'(tail_b.id)*DW +: DW] <= tail_b.port ? ram_q_b : ram_q_a;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter
// Drives per-requester operation queues into the arbiter, models the RAM
// macro behind it, and scores every grant and read return against a
// reference arbiter plus reference memory.
module tb_dpram_port_arbiter;

    localparam int N_REQ   = 4;
    localparam int AW      = 6;
    localparam int DW      = 8;
    localparam int RAM_LAT = 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [N_REQ*DW-1:0] rdata;
    logic                ram_we_a, ram_we_b;
    logic [AW-1:0]       ram_addr_a, ram_addr_b;
    logic [DW-1:0]       ram_data_a, ram_data_b;
    logic [DW-1:0]       ram_q_a, ram_q_b;

    op_t  op_q [N_REQ][$];
    exp_t sb_q [N_REQ][$];

    logic [DW-1:0] ram_mem [2**AW] = '{default: '0};
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
    logic [DW-1:0] qa_pipe [RAM_LAT] = '{default: '0};
    logic [DW-1:0] qb_pipe [RAM_LAT] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_seen  = 0;
    int n_exp_rd = 0;
    int n_got_rd = 0;
    int mrr      = 0;
    int m_fa, m_fb, m_j, m_last;
    logic [N_REQ-1:0] exp_gnt;
    logic [N_REQ-1:0] last_gnt = '0;
    exp_t e;

    dpram_port_arbiter #(
        .N_REQ  (N_REQ),
        .AW     (AW),
        .DW     (DW),
        .RAM_LAT(RAM_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_we_a  (ram_we_a),
        .ram_addr_a(ram_addr_a),
        .ram_data_a(ram_data_a),
        .ram_q_a   (ram_q_a),
        .ram_we_b  (ram_we_b),
        .ram_addr_b(ram_addr_b),
        .ram_data_b(ram_data_b),
        .ram_q_b   (ram_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RAM macro: synchronous write, read data RAM_LAT cycles after the command.
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
        qa_pipe[0] <= ram_mem[ram_addr_a];
        qb_pipe[0] <= ram_mem[ram_addr_b];
        for (int s = 1; s < RAM_LAT; s++) begin
            qa_pipe[s] <= qa_pipe[s-1];
            qb_pipe[s] <= qb_pipe[s-1];
        end
    end
    assign ram_q_a = qa_pipe[RAM_LAT-1];
    assign ram_q_b = qb_pipe[RAM_LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Monitor: score returns, then predict this cycle's grants and queue expected reads.
    always @(negedge clk) begin
        last_gnt = gnt;
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                n_exp_rd -= sb_q[i].size();
                sb_q[i].delete();
            end
            mrr = 0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rvalid[i]) begin
                    rv_seen++;
                    if (sb_q[i].size() == 0) begin
                        check_eq($sformatf("rvalid_unexpected[%0d]", i), 64'(rvalid[i]), 64'd0);
                    end else begin
                        e = sb_q[i].pop_front();
                        n_got_rd++;
                        check_eq($sformatf("rdata[%0d]", i), 64'(rdata[i*DW +: DW]), 64'(e.data));
                        check_eq($sformatf("ret_cycle[%0d]", i), 64'(cyc), 64'(e.due));
                    end
                end else if (sb_q[i].size() != 0 && sb_q[i][0].due <= cyc) begin
                    check_eq($sformatf("rvalid_missing[%0d]", i), 64'(rvalid[i]), 64'd1);
                    void'(sb_q[i].pop_front());
                end
            end

            m_fa = -1;
            m_fb = -1;
            m_last = 0;
            for (int k = 0; k < N_REQ; k++) begin
                m_j = (mrr + k) % N_REQ;
                if (req[m_j]) begin
                    if (m_fa < 0) m_fa = m_j;
                    else if (m_fb < 0) m_fb = m_j;
                end
            end
            exp_gnt = '0;
            if (m_fa >= 0) begin
                exp_gnt[m_fa] = 1'b1;
                m_last = m_fa;
            end
            if (m_fb >= 0 && !(req_addr[m_fa*AW +: AW] == req_addr[m_fb*AW +: AW] &&
                               (req_we[m_fa] || req_we[m_fb]))) begin
                exp_gnt[m_fb] = 1'b1;
                m_last = m_fb;
            end
            check_eq("gnt", 64'(gnt), 64'(exp_gnt));

            for (int i = 0; i < N_REQ; i++) begin
                if (exp_gnt[i] && !req_we[i]) begin
                    sb_q[i].push_back('{data: ref_mem[req_addr[i*AW +: AW]], due: cyc + 2 + RAM_LAT});
                    n_exp_rd++;
                end
            end
            for (int i = 0; i < N_REQ; i++)
                if (exp_gnt[i] && req_we[i]) ref_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
            if (m_fa >= 0) mrr = (m_last + 1) % N_REQ;
        end
    end

    // Driver: retire the op granted last cycle, present the next one (held until granted).
    initial begin
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (last_gnt[i] && op_q[i].size() != 0) void'(op_q[i].pop_front());
                if (op_q[i].size() != 0) begin
                    req[i]                 = 1'b1;
                    req_we[i]              = op_q[i][0].we;
                    req_addr[i*AW +: AW]   = op_q[i][0].addr;
                    req_wdata[i*DW +: DW]  = op_q[i][0].data;
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    end

    task automatic push_op(input int id, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        op_q[id].push_back('{we: we, addr: addr, data: data});
    endtask

    task automatic wait_idle(input string tag);
        int busy;
        busy = 1;
        for (int c = 0; c < 300 && busy != 0; c++) begin
            @(negedge clk);
            #1;
            busy = 0;
            for (int i = 0; i < N_REQ; i++) busy += op_q[i].size() + sb_q[i].size();
        end
        if (busy != 0) check_eq({tag, "_timeout"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [N_REQ];
        int rv0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_gnt", 64'(gnt), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_rdata", 64'(rdata), 64'd0);
        check_eq("rst_port_a", 64'({ram_we_a, ram_addr_a, ram_data_a}), 64'd0);
        check_eq("rst_port_b", 64'({ram_we_b, ram_addr_b, ram_data_b}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Preload addr 10 and 20 from id3
        push_op(3, 1'b1, 6'd10, 8'hA1);
        push_op(3, 1'b1, 6'd20, 8'hB2);
        wait_idle("preload");

        // T2: write then read from one requester on consecutive cycles
        push_op(0, 1'b1, 6'd3, 8'h5A);
        push_op(0, 1'b0, 6'd3, 8'h00);
        wait_idle("t2");
        check_eq("t2_rdata0", 64'(rdata[7:0]), 64'h5A);

        // T3: two reads issued together, id1 on port A and id2 on port B
        push_op(1, 1'b0, 6'd10, 8'h00);
        push_op(2, 1'b0, 6'd20, 8'h00);
        @(negedge clk);
        #1;
        check_eq("t3_gnt", 64'(gnt), 64'b0110);
        @(negedge clk);
        #1;
        check_eq("t3_addr_a", 64'(ram_addr_a), 64'd10);
        check_eq("t3_addr_b", 64'(ram_addr_b), 64'd20);
        wait_idle("t3");
        check_eq("t3_rdata1", 64'(rdata[15:8]), 64'hA1);
        check_eq("t3_rdata2", 64'(rdata[23:16]), 64'hB2);

        // T4: write/read collision on one address with the pointer at 0
        push_op(3, 1'b0, 6'd0, 8'h00);
        wait_idle("t4_align");
        push_op(0, 1'b1, 6'd7, 8'h77);
        push_op(1, 1'b0, 6'd7, 8'h00);
        @(negedge clk);
        #1;
        check_eq("t4_gnt_first", 64'(gnt), 64'b0001);
        @(negedge clk);
        #1;
        check_eq("t4_gnt_second", 64'(gnt), 64'b0010);
        wait_idle("t4");
        check_eq("t4_rdata1", 64'(rdata[15:8]), 64'h77);

        // T1: reset one cycle after a read is granted; that read must never return
        push_op(0, 1'b0, 6'h2A, 8'h00);
        @(negedge clk);
        #1;
        check_eq("t1_gnt", 64'(gnt), 64'b0001);
        @(negedge clk);
        #1;
        check_eq("t1_addr_a", 64'(ram_addr_a), 64'h2A);
        rst_n = 1'b0;
        #1;
        check_eq("t1_gnt_rst", 64'(gnt), 64'd0);
        check_eq("t1_rvalid_rst", 64'(rvalid), 64'd0);
        check_eq("t1_rdata_rst", 64'(rdata), 64'd0);
        check_eq("t1_port_a_rst", 64'({ram_we_a, ram_addr_a, ram_data_a}), 64'd0);
        check_eq("t1_port_b_rst", 64'({ram_we_b, ram_addr_b, ram_data_b}), 64'd0);
        repeat (2) @(negedge clk);
        rv0 = rv_seen;
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check_eq("t1_no_rvalid", 64'(rv_seen - rv0), 64'd0);

        // T5: all four requesters busy for 40 cycles
        for (int i = 0; i < N_REQ; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 20; k++) push_op(i, 1'b0, AW'(i * 8 + (k % 8)), 8'h00);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) if (gnt[i]) cnt[i]++;
            if (c < 4) check_eq($sformatf("t5_order%0d", c), 64'(gnt),
                                (c % 2 == 0) ? 64'b0011 : 64'b1100);
        end
        for (int i = 0; i < N_REQ; i++) check_eq($sformatf("t5_count%0d", i), 64'(cnt[i]), 64'd20);
        wait_idle("t5");

        // T6: random mix over a small address window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++)
                if (op_q[i].size() < 2 && $urandom_range(0, 99) < 60)
                    push_op(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
        end
        wait_idle("t6");
        check_eq("t6_return_count", 64'(n_got_rd), 64'(n_exp_rd));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
